// File: rtl/pe_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pe_result_buffer                                                 |
// | Brief   : FWFT result FIFO for a PE with no backpressure: almost_full      |
// |           stall hint, sticky overflow on drop. Optional stats counters     |
// |           enabled by PE_RESULT_BUFFER_STATS_EN.                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pe_result_buffer #(
  parameter int DEPTH        = 32,
  parameter int AFULL_MARGIN = 16,
  parameter int DWIDTH_FLOAT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH_FLOAT-1:0]    in_data,
  input  logic                       in_tvalid,
  input  logic                       in_tlast,
  input  logic                       flush,
  output logic [DWIDTH_FLOAT-1:0]    m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PE_RESULT_BUFFER_STATS_EN
  ,
  output logic [31:0]                beat_cnt,
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [DWIDTH_FLOAT:0] r_mem [DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DWIDTH_FLOAT:0] w_head;

  assign w_full = (r_count == c_CW'(DEPTH));
  assign w_pop  = (r_count != '0) && m_tready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_push = in_tvalid && (!w_full || w_pop);
  assign w_drop = in_tvalid && w_full && !w_pop;
  assign w_head = r_mem[r_rd_ptr];

  assign m_tdata     = w_head[DWIDTH_FLOAT-1:0];
  assign m_tlast     = w_head[DWIDTH_FLOAT];
  assign m_tvalid    = (r_count != '0);
  assign almost_full = (r_count >= c_CW'(DEPTH - AFULL_MARGIN));
  assign overflow    = r_overflow;
  assign count       = r_count;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) begin
      r_mem[r_wr_ptr] <= {in_tlast, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef PE_RESULT_BUFFER_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  // Flush suppresses the pop/drop it overrides, but never clears the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (!flush) begin
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
        if (m_tlast) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pe_result_buffer                                              |
// | Brief   : Scoreboard bench for pe_result_buffer, queue-based reference.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pe_result_buffer;

  localparam int DEPTH        = 32;
  localparam int AFULL_MARGIN = 16;
  localparam int DW           = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_tvalid;
  logic          in_tlast;
  logic          flush;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          almost_full;
  logic          overflow;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef PE_RESULT_BUFFER_STATS_EN
  logic [31:0] beat_cnt;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  pe_result_buffer #(
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN),
    .DWIDTH_FLOAT (DW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_tvalid   (in_tvalid),
    .in_tlast    (in_tlast),
    .flush       (flush),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .almost_full (almost_full),
    .overflow    (overflow),
    .count       (count)
`ifdef PE_RESULT_BUFFER_STATS_EN
    ,
    .beat_cnt    (beat_cnt),
    .pkt_cnt     (pkt_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference: mdl_q is the FIFO content, exp_q the scoreboard of beats still owed.
  logic [DW:0] mdl_q[$];
  logic [DW:0] exp_q[$];
  logic        mdl_ovf = 1'b0;
  longint      mdl_beats = 0;
  longint      mdl_pkts  = 0;
  longint      mdl_drops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_ovf   = 1'b0;
      mdl_beats = 0;
      mdl_pkts  = 0;
      mdl_drops = 0;
    end else if (flush) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      if (mdl_q.size() > 0 && m_tready) begin
        logic [DW:0] popped;
        popped = mdl_q.pop_front();
        mdl_beats = (mdl_beats + 1) % 64'h1_0000_0000;
        if (popped[DW]) mdl_pkts = (mdl_pkts + 1) % 65536;
      end
      if (in_tvalid) begin
        if (mdl_q.size() < DEPTH) begin
          mdl_q.push_back({in_tlast, in_data});
          exp_q.push_back({in_tlast, in_data});
        end else begin
          mdl_ovf = 1'b1;
          if (mdl_drops < 65535) mdl_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("count", 64'(count), 64'(mdl_q.size()));
    chk("m_tvalid", 64'(m_tvalid), 64'(mdl_q.size() > 0));
    chk("almost_full", 64'(almost_full), 64'(mdl_q.size() >= DEPTH - AFULL_MARGIN));
    chk("overflow", 64'(overflow), 64'(mdl_ovf));
`ifdef PE_RESULT_BUFFER_STATS_EN
    chk("beat_cnt", 64'(beat_cnt), 64'(mdl_beats));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkts));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdl_drops));
`endif
    if (m_tvalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL head: got 0x%0h with no beat expected at %0t", {m_tlast, m_tdata}, $time);
      end else begin
        chk("head", 64'({m_tlast, m_tdata}), 64'(exp_q[0]));
        if (m_tready && !flush && !rst) begin
          logic [DW:0] dummy;
          dummy = exp_q.pop_front();
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l,
                     input logic rdy, input logic fl, input logic r);
    in_tvalid = v;
    in_data   = d;
    in_tlast  = l;
    m_tready  = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_tvalid = 1'b0; in_data = '0; in_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);

    // Streaming through an empty FIFO: 8 beats, last on 8.
    for (int i = 1; i <= 8; i++) cyc(1, DW'(i), i == 8, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);

    // Fill with no drain: almost_full at 16, full at 32, 33rd dropped.
    for (int i = 1; i <= 33; i++) cyc(1, DW'(32'h100 + i), i[2:0] == 3'd0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    chk("head_after_drop", 64'(m_tdata), 64'(32'h101));
    chk("count_full", 64'(count), 64'(DEPTH));

    // Full with simultaneous push and pop for 10 cycles.
    for (int i = 0; i < 10; i++) cyc(1, DW'(32'h200 + i), 1'b0, 1, 0, 0);
    chk("count_full_stream", 64'(count), 64'(DEPTH));
    repeat (DEPTH + 2) cyc(0, 0, 0, 1, 0, 0);

    // Flush at count 12 together with a push.
    for (int i = 0; i < 12; i++) cyc(1, DW'(32'h300 + i), 1'b0, 0, 0, 0);
    cyc(1, 32'hDEAD, 1'b1, 0, 1, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(m_tvalid), 64'd0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);

`ifdef PE_RESULT_BUFFER_STATS_EN
    // 3 packets of 5 popped beats plus one drop, then a flush.
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 33; i++) cyc(1, DW'(i), (i % 5) == 0 && i <= 15, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("stats_beat", 64'(beat_cnt), 64'd15);
    chk("stats_pkt", 64'(pkt_cnt), 64'd3);
    chk("stats_drop", 64'(drop_cnt), 64'd1);
    cyc(0, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 6) == 0,
          ($urandom % 3) != 0 || (i / 200) % 2 == 1,
          ($urandom % 97) == 0, ($urandom % 401) == 0);
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 4 * DEPTH && count != 0; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("drained_count", 64'(count), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_result_buffer.md
PE_RESULT_BUFFER -- requirements
Module: pe_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, FIFO entries; a power of two, minimum 4.
REQ-002 SHALL have parameter AFULL_MARGIN, default 16, free entries reserved for upstream PE pipeline drain; must be less than DEPTH.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, dwidth_float, PE result data.
REQ-006 SHALL have port in_tvalid, input, 1, PE result valid; there is no ready toward the PE.
REQ-007 SHALL have port in_tlast, input, 1, PE result last beat.
REQ-008 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-009 SHALL have port m_tdata, output, dwidth_float, head entry data.
REQ-010 SHALL have port m_tvalid, output, 1, head entry valid.
REQ-011 SHALL have port m_tlast, output, 1, head entry last flag.
REQ-012 SHALL have port m_tready, input, 1, downstream accept.
REQ-013 SHALL have port almost_full, output, 1, upstream issue-stall request.
REQ-014 SHALL have port overflow, output, 1, sticky indication that a beat was dropped.
REQ-015 SHALL have port count, output, clog2(DEPTH+1), current occupancy.

Function
REQ-016 SHALL act as a synchronous FIFO storing {in_tlast, in_data} per accepted beat, with a registered pointer and count.
REQ-017 SHALL perform a push when in_tvalid=1 and either count<DEPTH, or count=DEPTH and a pop occurs in the same cycle.
REQ-018 SHALL perform a pop when m_tvalid=1 and m_tready=1.
REQ-019 SHALL drive m_tvalid=1 exactly when count>0, with m_tdata and m_tlast showing the head entry (first-word-fall-through).
REQ-020 SHALL make a pushed beat visible at m_tvalid on the cycle after the push, giving 1-cycle latency through an empty FIFO.
REQ-021 SHALL increase count by 1 on a push alone, decrease it by 1 on a pop alone, and leave it unchanged on a simultaneous push and pop.
REQ-022 SHALL wrap both pointers modulo DEPTH.
REQ-023 SHALL assert almost_full combinationally from the registered count whenever count >= DEPTH-AFULL_MARGIN.
REQ-024 SHALL, when in_tvalid=1 and count=DEPTH with no pop, drop the beat, leave the FIFO contents unchanged, and set overflow to 1 on the next cycle.
REQ-025 SHALL clear overflow only on rst or flush.
REQ-026 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-027 SHALL, on flush=1, set count to 0, reset both pointers and clear overflow on the next cycle, ignoring any concurrent push or pop.
REQ-028 SHALL give flush priority over a simultaneous push or pop.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, set count=0, pointers=0, m_tvalid=0, overflow=0 and almost_full=0.
REQ-030 SHALL treat rst asserted mid-packet exactly like flush, with no partial-packet recovery.
REQ-031 SHALL not reset the storage array contents.

Configuration
REQ-032 SHALL, with PE_RESULT_BUFFER_STATS_EN defined, add output beat_cnt (32 bits) that increments on every pop and wraps at 2^32.
REQ-033 SHALL, with PE_RESULT_BUFFER_STATS_EN defined, add output pkt_cnt (16 bits) that increments on every pop with m_tlast=1 and wraps at 2^16.
REQ-034 SHALL, with PE_RESULT_BUFFER_STATS_EN defined, add output drop_cnt (16 bits) that increments on every dropped beat and saturates at 0xFFFF.
REQ-035 SHALL clear beat_cnt, pkt_cnt and drop_cnt on rst only; flush leaves them unchanged.
REQ-036 SHALL, without PE_RESULT_BUFFER_STATS_EN, omit these ports and their logic entirely, leaving all other behaviour identical.

Verification
REQ-037 SHALL cover: with DEPTH=32 and m_tready=1, push 8 beats (data 1..8, tlast on 8) -> m_tdata 1..8 in order, each 1 cycle after push, m_tlast only with 8, count never exceeds 1.
REQ-038 SHALL cover: with m_tready=0, push 16 beats -> almost_full=1 once count=16, overflow=0.
REQ-039 SHALL cover: with m_tready=0, push 33 beats -> count=32, 33rd beat dropped, overflow=1 from the next cycle, head still beat 1.
REQ-040 SHALL cover: FIFO full while m_tready=1 and in_tvalid=1 for 10 cycles -> count stays 32, no drop, output order preserved.
REQ-041 SHALL cover: flush with count=12 asserted together with a push -> count=0 and m_tvalid=0 the next cycle, and the pushed beat is not stored.
REQ-042 SHALL cover: with stats enabled, pop 3 packets of 5 beats plus 1 drop -> beat_cnt=15, pkt_cnt=3, drop_cnt=1, counters unchanged by a following flush.
